fir_coeff_reload_ctrl: RTL and testbench

Sequencer that owns the coefficient-reload and config ports of the 4-channel FIR filter block. It holds a host-writable shadow bank of coefficients. On a reload request it waits for the filter's channel sequencer to go idle, then streams the bank over the AXI-stream reload port with tlast on the final word. It then issues one config packet and releases the data path. It sits between the host register bus (FireWire write decode) and the FIR filter instance, and gates the filter's sample trigger while a reload is in flight.

---
 rtl/fir_coeff_reload_ctrl_if.sv | 11 +
 rtl/fir_coeff_reload_ctrl.sv | 88 ++++++++
 tb/tb_fir_coeff_reload_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_coeff_reload_ctrl_if.sv
// fir_coeff_reload_ctrl_if: coefficient reload stream and config handshake towards the FIR filter
interface fir_coeff_reload_ctrl_if;
    logic        reload_valid;
    logic        reload_ready;
    logic        reload_last;
    logic [15:0] coeff;
    logic        config_valid;
    logic        config_ready;
    modport master(output reload_valid, reload_last, coeff, config_valid, input reload_ready, config_ready);
    modport slave(input reload_valid, reload_last, coeff, config_valid, output reload_ready, config_ready);
endinterface

// File: rtl/fir_coeff_reload_ctrl.sv
// fir_coeff_reload_ctrl: shadow coefficient bank streamed to the FIR filter on request, then one config packet
module fir_coeff_reload_ctrl #(
    parameter int NUM_COEFF = 21,
    parameter int TIMEOUT   = 255
) (
    input  logic                        clkfir,
    input  logic                        reset,
    input  logic                        coeff_wen,
    input  logic [4:0]                  coeff_waddr,
    input  logic signed [15:0]          coeff_wdata,
    input  logic                        load_req,
    input  logic                        fir_busy,
    fir_coeff_reload_ctrl_if.master     fir,
    output logic                        data_inhibit,
    output logic                        done,
    output logic                        err_timeout,
    output logic                        err_wr_conflict
);
    typedef enum logic [2:0] {IDLE, WAIT_IDLE, STREAM, CONFIG, DONE} state_t;
    localparam logic [4:0] LAST = 5'(NUM_COEFF - 1);
    state_t      state, state_n;
    logic [15:0] bank [32];
    logic [4:0]  idx, idx_n;
    logic [15:0] coeff_n;
    logic [15:0] stall_cnt;
    logic        pending, pending_n;
    logic        wr_ok, stalled;
    assign wr_ok   = coeff_wen && state != STREAM && int'(coeff_waddr) < NUM_COEFF;
    assign stalled = state == STREAM && !fir.reload_ready;
    always_ff @(posedge clkfir)
        if (wr_ok) bank[coeff_waddr] <= coeff_wdata;
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        coeff_n   = fir.coeff;
        pending_n = pending | (load_req && state != IDLE);
        case (state)
            IDLE: if (load_req) state_n = WAIT_IDLE;
            WAIT_IDLE: if (!fir_busy) begin
                state_n = STREAM;
                idx_n   = '0;
                // a write landing this same cycle must still reach word 0
                coeff_n = (wr_ok && coeff_waddr == 5'd0) ? coeff_wdata : bank[0];
            end
            STREAM: if (fir.reload_ready) begin
                idx_n   = idx + 5'd1;
                coeff_n = bank[idx + 5'd1];
                if (idx == LAST) state_n = CONFIG;
            end
            CONFIG: if (fir.config_ready) state_n = DONE;
            DONE: begin
                state_n   = pending_n ? WAIT_IDLE : IDLE;
                pending_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end
    // outputs are registered from the next state so they line up with it
    always_ff @(posedge clkfir) begin
        if (reset) begin
            state            <= IDLE;
            idx              <= '0;
            pending          <= 1'b0;
            stall_cnt        <= '0;
            fir.coeff        <= '0;
            fir.reload_valid <= 1'b0;
            fir.reload_last  <= 1'b0;
            fir.config_valid <= 1'b0;
            data_inhibit     <= 1'b0;
            done             <= 1'b0;
            err_timeout      <= 1'b0;
            err_wr_conflict  <= 1'b0;
        end else begin
            state            <= state_n;
            idx              <= idx_n;
            pending          <= pending_n;
            stall_cnt        <= stalled ? (stall_cnt < 16'(TIMEOUT) ? stall_cnt + 16'd1 : stall_cnt) : '0;
            fir.coeff        <= coeff_n;
            fir.reload_valid <= state_n == STREAM;
            fir.reload_last  <= state_n == STREAM && idx_n == LAST;
            fir.config_valid <= state_n == CONFIG;
            data_inhibit     <= state_n != IDLE;
            done             <= state_n == DONE;
            err_timeout      <= err_timeout | (stalled && stall_cnt == 16'(TIMEOUT - 1));
            err_wr_conflict  <= err_wr_conflict | (coeff_wen && state == STREAM);
        end
    end
endmodule

// File: tb/tb_fir_coeff_reload_ctrl.sv
// tb_fir_coeff_reload_ctrl: directed checks of reload sequencing, backpressure, pending merge and error flags
module tb_fir_coeff_reload_ctrl;
    logic        clkfir = 0;
    logic        reset = 1;
    logic        coeff_wen = 0;
    logic [4:0]  coeff_waddr = 0;
    logic [15:0] coeff_wdata = 0;
    logic        load_req = 0;
    logic        fir_busy = 0;
    logic        data_inhibit, done, err_timeout, err_wr_conflict;
    int          tests = 0;
    int          failed = 0;
    logic [15:0] cap [64];
    logic        cap_last [64];
    int          ncap, ndone, unstable, inhibit_drop;
    fir_coeff_reload_ctrl_if rl_if();
    fir_coeff_reload_ctrl #(.NUM_COEFF(21), .TIMEOUT(255)) dut (
        .clkfir(clkfir), .reset(reset), .coeff_wen(coeff_wen), .coeff_waddr(coeff_waddr),
        .coeff_wdata(coeff_wdata), .load_req(load_req), .fir_busy(fir_busy), .fir(rl_if.master),
        .data_inhibit(data_inhibit), .done(done), .err_timeout(err_timeout), .err_wr_conflict(err_wr_conflict)
    );
    always #5 clkfir = ~clkfir;
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    task automatic tick;
        @(posedge clkfir);
        #1;
    endtask
    task automatic write_bank;
        for (int i = 0; i < 21; i++) begin
            coeff_wen = 1; coeff_waddr = 5'(i); coeff_wdata = 16'(i + 1);
            tick;
        end
        coeff_wen = 0;
    endtask
    // drives ready/load_req/write per cycle and records accepted words until 'want' done pulses
    task automatic collect(input int mode, input int want, input int maxc, input int r1, input int r2,
                           input int wr_at, input logic [4:0] wa, input logic [15:0] wd);
        logic [17:0] held;
        logic stall;
        ncap = 0; ndone = 0; unstable = 0; inhibit_drop = 0; stall = 0; held = '0;
        for (int c = 0; c < maxc && ndone < want; c++) begin
            rl_if.reload_ready = mode == 0 || c % 4 == 0 || c % 4 == 3;
            load_req = c == r1 || c == r2;
            coeff_wen = c == wr_at;
            coeff_waddr = wa; coeff_wdata = wd;
            if (stall && {rl_if.reload_valid, rl_if.reload_last, rl_if.coeff} !== held) unstable++;
            stall = rl_if.reload_valid && !rl_if.reload_ready;
            held = {rl_if.reload_valid, rl_if.reload_last, rl_if.coeff};
            if (rl_if.reload_valid && rl_if.reload_ready && ncap < 64) begin
                cap[ncap] = rl_if.coeff; cap_last[ncap] = rl_if.reload_last; ncap++;
            end
            if (ndone > 0 && !data_inhibit) inhibit_drop++;
            if (done) ndone++;
            tick;
        end
        load_req = 0; coeff_wen = 0; rl_if.reload_ready = 1;
    endtask
    task automatic test_reset;
        rl_if.reload_ready = 1; rl_if.config_ready = 1;
        reset = 1; load_req = 1;
        tick; tick;
        tests++;
        if ({rl_if.reload_valid, rl_if.reload_last, rl_if.config_valid, data_inhibit, done, err_timeout, err_wr_conflict} !== 7'b0) begin
            failed++; $display("FAIL reset_flags got %b exp 0000000", {rl_if.reload_valid, rl_if.reload_last, rl_if.config_valid, data_inhibit, done, err_timeout, err_wr_conflict});
        end
        tests++;
        if (rl_if.coeff !== 16'h0) begin failed++; $display("FAIL reset_coeff got %h exp 0000", rl_if.coeff); end
        reset = 0; load_req = 0;
        tick; tick; tick;
        tests++;
        if (data_inhibit !== 1'b0 || rl_if.reload_valid !== 1'b0) begin
            failed++; $display("FAIL reset_req_ignored got inhibit %b valid %b exp 0 0", data_inhibit, rl_if.reload_valid);
        end
    endtask
    task automatic test_basic;
        logic [4:0] exp_f, got_f;
        load_req = 1; tick; load_req = 0;
        for (int k = 1; k <= 26; k++) begin
            exp_f = {k >= 2 && k <= 22, k == 22, k == 23, k == 24, k >= 1 && k <= 24};
            got_f = {rl_if.reload_valid, rl_if.reload_last, rl_if.config_valid, done, data_inhibit};
            tests++;
            if (got_f !== exp_f) begin failed++; $display("FAIL basic_flags cycle T+%0d got %b exp %b", k, got_f, exp_f); end
            if (k >= 2 && k <= 22) begin
                tests++;
                if (rl_if.coeff !== 16'(k - 1)) begin failed++; $display("FAIL basic_coeff cycle T+%0d got %h exp %h", k, rl_if.coeff, 16'(k - 1)); end
            end
            tick;
        end
    endtask
    task automatic test_load_with_write;
        collect(0, 1, 100, 0, -1, 0, 5'd0, 16'h1234);
        tests++;
        if (ndone !== 1 || ncap !== 21) begin failed++; $display("FAIL lww_count got done %0d words %0d exp 1 21", ndone, ncap); end
        tests++;
        if (cap[0] !== 16'h1234) begin failed++; $display("FAIL lww_word0 got %h exp 1234", cap[0]); end
        coeff_wen = 1; coeff_waddr = 0; coeff_wdata = 16'd1; tick; coeff_wen = 0;
    endtask
    task automatic test_backpressure;
        collect(1, 1, 200, 0, -1, -1, 5'd0, 16'h0);
        tests++;
        if (ndone !== 1 || ncap !== 21) begin failed++; $display("FAIL bp_count got done %0d words %0d exp 1 21", ndone, ncap); end
        tests++;
        if (unstable !== 0) begin failed++; $display("FAIL bp_stable got %0d unstable stalls exp 0", unstable); end
        for (int i = 0; i < ncap; i++) begin
            tests++;
            if ({cap_last[i], cap[i]} !== {i % 21 == 20, 16'(i % 21 + 1)}) begin
                failed++; $display("FAIL bp_word %0d got %b/%h exp %b/%h", i, cap_last[i], cap[i], i % 21 == 20, 16'(i % 21 + 1));
            end
        end
    endtask
    task automatic test_fir_busy;
        int bad;
        bad = 0;
        fir_busy = 1; load_req = 1; tick; load_req = 0;
        for (int i = 0; i < 50; i++) begin
            if (rl_if.reload_valid !== 1'b0 || data_inhibit !== 1'b1) bad++;
            tick;
        end
        tests++;
        if (bad !== 0) begin failed++; $display("FAIL busy_hold got %0d bad cycles exp 0", bad); end
        fir_busy = 0;
        tests++;
        if (rl_if.reload_valid !== 1'b0) begin failed++; $display("FAIL busy_fall_same got valid %b exp 0", rl_if.reload_valid); end
        tick;
        tests++;
        if (rl_if.reload_valid !== 1'b1 || rl_if.coeff !== 16'd1) begin
            failed++; $display("FAIL busy_start got valid %b coeff %h exp 1 0001", rl_if.reload_valid, rl_if.coeff);
        end
        collect(0, 1, 100, -1, -1, -1, 5'd0, 16'h0);
        tests++;
        if (ndone !== 1 || ncap !== 21) begin failed++; $display("FAIL busy_count got done %0d words %0d exp 1 21", ndone, ncap); end
    endtask
    task automatic test_back_to_back;
        int extra;
        extra = 0;
        collect(0, 2, 200, 0, 5, -1, 5'd0, 16'h0);
        tests++;
        if (ndone !== 2 || ncap !== 42) begin failed++; $display("FAIL b2b_count got done %0d words %0d exp 2 42", ndone, ncap); end
        tests++;
        if (inhibit_drop !== 0) begin failed++; $display("FAIL b2b_inhibit got %0d drop cycles exp 0", inhibit_drop); end
        for (int i = 0; i < ncap; i++) begin
            tests++;
            if ({cap_last[i], cap[i]} !== {i % 21 == 20, 16'(i % 21 + 1)}) begin
                failed++; $display("FAIL b2b_word %0d got %b/%h exp %b/%h", i, cap_last[i], cap[i], i % 21 == 20, 16'(i % 21 + 1));
            end
        end
        for (int i = 0; i < 10; i++) begin
            if (rl_if.reload_valid || data_inhibit || done) extra++;
            tick;
        end
        tests++;
        if (extra !== 0) begin failed++; $display("FAIL b2b_no_third got %0d active cycles exp 0", extra); end
    endtask
    task automatic test_wr_conflict;
        collect(0, 1, 100, 0, -1, 6, 5'd3, 16'hdead);
        tests++;
        if (err_wr_conflict !== 1'b1) begin failed++; $display("FAIL wrc_flag got %b exp 1", err_wr_conflict); end
        collect(0, 1, 100, 0, -1, -1, 5'd0, 16'h0);
        tests++;
        if (ncap !== 21 || cap[3] !== 16'd4) begin failed++; $display("FAIL wrc_bank3 got words %0d bank3 %h exp 21 0004", ncap, cap[3]); end
        tests++;
        if (err_wr_conflict !== 1'b1) begin failed++; $display("FAIL wrc_sticky got %b exp 1", err_wr_conflict); end
    endtask
    task automatic test_timeout;
        rl_if.reload_ready = 0;
        load_req = 1; tick; load_req = 0; tick;
        for (int i = 0; i < 250; i++) tick;
        tests++;
        if (err_timeout !== 1'b0 || rl_if.reload_valid !== 1'b1) begin
            failed++; $display("FAIL to_early got err %b valid %b exp 0 1", err_timeout, rl_if.reload_valid);
        end
        for (int i = 0; i < 50; i++) tick;
        tests++;
        if (err_timeout !== 1'b1 || rl_if.reload_valid !== 1'b1 || rl_if.coeff !== 16'd1) begin
            failed++; $display("FAIL to_set got err %b valid %b coeff %h exp 1 1 0001", err_timeout, rl_if.reload_valid, rl_if.coeff);
        end
        collect(0, 1, 100, -1, -1, -1, 5'd0, 16'h0);
        tests++;
        if (ndone !== 1 || ncap !== 21 || cap[20] !== 16'd21 || cap_last[20] !== 1'b1) begin
            failed++; $display("FAIL to_resume got done %0d words %0d last %h exp 1 21 0015", ndone, ncap, cap[20]);
        end
        tests++;
        if (err_timeout !== 1'b1) begin failed++; $display("FAIL to_sticky got %b exp 1", err_timeout); end
    endtask
    task automatic test_reset_mid_stream;
        load_req = 1; tick; load_req = 0;
        for (int i = 0; i < 5; i++) tick;
        reset = 1; load_req = 1; tick;
        tests++;
        if ({rl_if.reload_valid, rl_if.reload_last, rl_if.config_valid, data_inhibit, done, err_timeout, err_wr_conflict} !== 7'b0 || rl_if.coeff !== 16'h0) begin
            failed++; $display("FAIL midrst_outputs got %b coeff %h exp 0000000 0000", {rl_if.reload_valid, rl_if.reload_last, rl_if.config_valid, data_inhibit, done, err_timeout, err_wr_conflict}, rl_if.coeff);
        end
        reset = 0; load_req = 0; tick; tick;
        tests++;
        if (data_inhibit !== 1'b0) begin failed++; $display("FAIL midrst_idle got inhibit %b exp 0", data_inhibit); end
    endtask
    initial begin
        rl_if.reload_ready = 1; rl_if.config_ready = 1;
        test_reset;
        write_bank;
        test_basic;
        test_load_with_write;
        test_backpressure;
        test_fir_busy;
        test_back_to_back;
        test_wr_conflict;
        test_timeout;
        test_reset_mid_stream;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
